// File: rtl/tmds_rx_channel.sv
// Single-lane TMDS receive decoder: hunts for the symbol boundary using runs of
// control tokens, then decodes 10-bit symbols into pixel bytes / control values.
module tmds_rx_channel #(
    parameter int TOKEN_RUN = 8,
    parameter int TIMEOUT   = 2047
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_valid,
    input  logic [9:0] I_raw,
    output logic       O_valid,
    output logic       O_de,
    output logic [7:0] O_data,
    output logic [1:0] O_ctrl,
    output logic       O_locked,
    output logic [3:0] O_offset
);
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [10:0] RUN_LIMIT  = 11'(TOKEN_RUN);
    localparam logic [10:0] TIME_LIMIT = 11'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [9:0]  prev_reg;
    logic [3:0]  offset_reg, offset_next;
    logic [10:0] run_reg, run_next;
    logic [10:0] cnt_reg, cnt_next;
    logic [1:0]  last_c_reg, last_c_next;

    logic        s1_valid_reg;
    logic [9:0]  s1_win_reg;
    logic        s1_tok_reg;
    logic [1:0]  s1_c_reg;

    logic [19:0] hist;
    logic [4:0]  win_lsb;
    logic [9:0]  win;
    logic        win_tok;
    logic [1:0]  win_c;
    logic [10:0] run_inc;
    logic [10:0] cnt_inc;
    logic [3:0]  offset_slip;
    logic [7:0]  dec_q;
    logic [7:0]  dec_d;

    // Offset k means the symbol began k bits before the current word boundary:
    // its first k bits are the newest bits of the previous word.
    assign hist    = {I_raw, prev_reg};
    assign win_lsb = 5'd10 - {1'b0, offset_reg};
    assign win     = hist[win_lsb +: 10];

    always_comb begin
        win_tok = 1'b1;
        win_c   = 2'b00;
        case (win)
            10'h354: win_c = 2'b00;
            10'h0AB: win_c = 2'b01;
            10'h154: win_c = 2'b10;
            10'h2AB: win_c = 2'b11;
            default: win_tok = 1'b0;
        endcase
    end

    assign offset_slip = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
    assign cnt_inc     = (cnt_reg >= TIME_LIMIT) ? TIME_LIMIT : cnt_reg + 11'd1;
    assign run_inc     = (win_tok && run_reg != 11'd0 && win_c == last_c_reg)
                       ? ((run_reg >= RUN_LIMIT) ? RUN_LIMIT : run_reg + 11'd1)
                       : {10'd0, win_tok};

    // cnt_reg is the word counter while searching and the gap counter while locked.
    always_comb begin
        state_next  = state_reg;
        offset_next = offset_reg;
        run_next    = run_reg;
        cnt_next    = cnt_reg;
        last_c_next = last_c_reg;
        if (I_valid) begin
            if (win_tok) begin
                last_c_next = win_c;
            end
            case (state_reg)
                SEARCH: begin
                    if (run_inc == RUN_LIMIT) begin
                        state_next = LOCKED;
                        run_next   = 11'd0;
                        cnt_next   = 11'd0;
                    end else if (cnt_inc == TIME_LIMIT) begin
                        offset_next = offset_slip;
                        run_next    = 11'd0;
                        cnt_next    = 11'd0;
                    end else begin
                        run_next = run_inc;
                        cnt_next = cnt_inc;
                    end
                end
                LOCKED: begin
                    if (win_tok) begin
                        cnt_next = 11'd0;
                    end else if (cnt_inc == TIME_LIMIT) begin
                        state_next  = SEARCH;
                        offset_next = offset_slip;
                        run_next    = 11'd0;
                        cnt_next    = 11'd0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    assign dec_q    = s1_win_reg[9] ? ~s1_win_reg[7:0] : s1_win_reg[7:0];
    assign dec_d[0] = dec_q[0];

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign dec_d[gi] = s1_win_reg[8] ? (dec_q[gi] ^ dec_q[gi-1])
                                             : ~(dec_q[gi] ^ dec_q[gi-1]);
        end
    endgenerate

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_reg    <= SEARCH;
            prev_reg     <= 10'd0;
            offset_reg   <= 4'd0;
            run_reg      <= 11'd0;
            cnt_reg      <= 11'd0;
            last_c_reg   <= 2'b00;
            s1_valid_reg <= 1'b0;
            s1_win_reg   <= 10'd0;
            s1_tok_reg   <= 1'b0;
            s1_c_reg     <= 2'b00;
        end else begin
            state_reg    <= state_next;
            offset_reg   <= offset_next;
            run_reg      <= run_next;
            cnt_reg      <= cnt_next;
            last_c_reg   <= last_c_next;
            s1_valid_reg <= I_valid;
            if (I_valid) begin
                prev_reg   <= I_raw;
                s1_win_reg <= win;
                s1_tok_reg <= win_tok;
                s1_c_reg   <= win_c;
            end
        end
    end

    // Stage 2 samples state/offset after the stage-1 word updated them, so
    // lock/slip show up on the output of the word that caused them.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_valid  <= 1'b0;
            O_de     <= 1'b0;
            O_data   <= 8'd0;
            O_ctrl   <= 2'b00;
            O_locked <= 1'b0;
            O_offset <= 4'd0;
        end else begin
            O_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                O_locked <= (state_reg == LOCKED);
                O_offset <= offset_reg;
                if (s1_tok_reg) begin
                    O_de   <= 1'b0;
                    O_data <= 8'd0;
                    O_ctrl <= s1_c_reg;
                end else begin
                    O_de   <= (state_reg == LOCKED);
                    O_data <= dec_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: word-level reference model with an output queue,
// video-like and randomized stimulus, plus literal lock/slip/data pins.
module tb_tmds_rx_channel;
    localparam int TOKEN_RUN = 8;
    localparam int TIMEOUT   = 2047;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [9:0] raw = 10'd0;
    logic       o_valid, o_de, o_locked;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic [3:0] o_offset;

    tmds_rx_channel #(.TOKEN_RUN(TOKEN_RUN), .TIMEOUT(TIMEOUT)) dut (
        .I_clk(clk), .I_rst(rst), .I_valid(valid), .I_raw(raw),
        .O_valid(o_valid), .O_de(o_de), .O_data(o_data), .O_ctrl(o_ctrl),
        .O_locked(o_locked), .O_offset(o_offset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       locked;
        logic [3:0] off;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    bit   checking = 1'b0;
    bit   src_check = 1'b0;

    logic [9:0] sym[0:8191];
    logic [7:0] src_byte[0:8191];
    logic [9:0] tokens[0:3];
    int         enc_cnt;

    // Reference model state (per accepted word)
    logic [9:0] m_prev;
    int         m_off, m_run, m_words, m_gap;
    bit         m_locked;
    logic [1:0] m_ctrl, m_lastc;

    // Recorder (owned by the compare process)
    int         out_idx, lock_idx, lock_off, lock_ctrl, fall_idx, fall_off, lk_mask;
    int         chg_idx[10];
    logic       prev_lk;
    logic [3:0] last_off;
    logic [1:0] vh;
    exp_t       e_cmp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] q, d;
        q = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~w[8];
        return d;
    endfunction

    // DVI encoder with running disparity
    task automatic tmds_encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
        end
    endtask

    task automatic model_word(input logic [9:0] w_raw);
        logic [19:0] h;
        logic [9:0]  win;
        int          tc;
        exp_t        e;
        h   = {w_raw, m_prev};
        win = 10'(h >> (10 - m_off));
        tc  = tok_code(win);
        if (!m_locked) begin
            m_run = (tc >= 0 && m_run > 0 && 2'(tc) == m_lastc) ? m_run + 1 : ((tc >= 0) ? 1 : 0);
            m_words++;
            if (m_run == TOKEN_RUN) begin
                m_locked = 1'b1; m_run = 0; m_words = 0; m_gap = 0;
            end else if (m_words == TIMEOUT) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_words = 0;
            end
        end else begin
            m_gap = (tc >= 0) ? 0 : m_gap + 1;
            if (m_gap == TIMEOUT) begin
                m_locked = 1'b0; m_off = (m_off + 1) % 10; m_gap = 0; m_run = 0; m_words = 0;
            end
        end
        if (tc >= 0) begin
            m_lastc = 2'(tc);
            m_ctrl  = 2'(tc);
            e.de = 1'b0; e.data = 8'd0;
        end else begin
            e.de = m_locked; e.data = tmds_decode(win);
        end
        e.ctrl = m_ctrl; e.locked = m_locked; e.off = 4'(m_off);
        exp_q.push_back(e);
        m_prev = w_raw;
    endtask

    task automatic drive(input bit v, input logic [9:0] w);
        @(posedge clk);
        #1;
        valid = v;
        raw   = w;
        if (v) model_word(w);
    endtask

    task automatic drain();
        repeat (4) drive(1'b0, 10'($urandom));
    endtask

    // 370 tokens then 1280 data bytes (0x00, 0xFF, 0x55, incrementing), repeated
    task automatic build_video(input int n);
        int p, k;
        logic [7:0] b;
        logic [9:0] q;
        enc_cnt = 0;
        for (int j = 0; j <= n; j++) begin
            p = j % 1650;
            if (p < 370) begin
                sym[j] = 10'h354; src_byte[j] = 8'd0; enc_cnt = 0;
            end else begin
                k = p - 370;
                b = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : (k == 2) ? 8'h55 : 8'(k);
                tmds_encode(b, q);
                sym[j] = q; src_byte[j] = b;
            end
        end
    endtask

    // Rotation r: each raw word starts r bits into the symbol stream
    task automatic run_video(input int n, input int rot);
        logic [19:0] pair;
        for (int j = 0; j < n; j++) begin
            pair = {sym[j+1], sym[j]};
            drive(1'b1, 10'(pair >> rot));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        checking = 1'b0;
        rst = 1'b1;
        valid = 1'b0;
        #1;
        check("rst_o_valid", 32'(o_valid), 0);
        check("rst_o_de", 32'(o_de), 0);
        check("rst_o_data", 32'(o_data), 0);
        check("rst_o_ctrl", 32'(o_ctrl), 0);
        check("rst_o_locked", 32'(o_locked), 0);
        check("rst_o_offset", 32'(o_offset), 0);
        repeat (2) @(negedge clk);
        m_prev = 10'd0; m_off = 0; m_run = 0; m_words = 0; m_gap = 0;
        m_locked = 1'b0; m_ctrl = 2'b00; m_lastc = 2'b00;
        rst = 1'b0;
        #1;
        checking = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!checking) begin
            exp_q.delete();
            vh = 2'b00; out_idx = 0; lock_idx = -1; lock_off = -1; lock_ctrl = -1;
            fall_idx = -1; fall_off = -1; lk_mask = 0; prev_lk = 1'b0; last_off = 4'd0;
            for (int i = 0; i < 10; i++) chg_idx[i] = -1;
        end else begin
            check("o_valid_delay2", 32'(o_valid), 32'(vh[1]));
            vh = {vh[0], valid};
            if (o_valid) begin
                out_idx++;
                if (exp_q.size() == 0) begin
                    check("model_queue_empty", 32'(out_idx), 0);
                end else begin
                    e_cmp = exp_q.pop_front();
                    check("o_de", 32'(o_de), 32'(e_cmp.de));
                    check("o_data", 32'(o_data), 32'(e_cmp.data));
                    check("o_ctrl", 32'(o_ctrl), 32'(e_cmp.ctrl));
                    check("o_locked", 32'(o_locked), 32'(e_cmp.locked));
                    check("o_offset", 32'(o_offset), 32'(e_cmp.off));
                end
                if (src_check && o_de) check("src_byte", 32'(o_data), 32'(src_byte[out_idx-1]));
                if (o_locked) lk_mask |= (1 << o_offset);
                if (o_locked && lock_idx < 0) begin
                    lock_idx = out_idx; lock_off = int'(o_offset); lock_ctrl = int'(o_ctrl);
                end
                if (prev_lk && !o_locked && fall_idx < 0) begin
                    fall_idx = out_idx; fall_off = int'(o_offset);
                end
                if (o_offset != last_off && o_offset < 4'd10 && chg_idx[o_offset] < 0)
                    chg_idx[o_offset] = out_idx;
                prev_lk  = o_locked;
                last_off = o_offset;
            end
        end
    end

    initial begin
        int         left;
        bit         btok;
        logic [9:0] bword, q;
        tokens[0] = 10'h354; tokens[1] = 10'h0AB; tokens[2] = 10'h154; tokens[3] = 10'h2AB;

        // Aligned stream, then asynchronous reset mid-data while locked
        do_reset();
        build_video(3300);
        src_check = 1'b1;
        run_video(2500, 0);
        check("aligned_lock_index", lock_idx, 8);
        check("aligned_lock_offset", lock_off, 0);
        check("aligned_locked_before_rst", 32'(o_locked), 1);
        do_reset();

        // Relock after reset within 8 tokens
        build_video(40);
        run_video(40, 0);
        drain();
        check("relock_index", lock_idx, 8);

        // Stream rotated by 3 bits: slips 0->1->2->3, locks only at 3
        do_reset();
        build_video(7400);
        run_video(7400, 3);
        drain();
        check("rot_slip1_index", chg_idx[1], 2047);
        check("rot_slip2_index", chg_idx[2], 4094);
        check("rot_slip3_index", chg_idx[3], 6141);
        check("rot_lock_index", lock_idx, 6608);
        check("rot_lock_offset", lock_off, 3);
        check("rot_lock_offsets_seen", lk_mask, 32'h8);

        // Mixed tokens never lock; a run of 0x154 locks with ctrl 2'b10
        do_reset();
        src_check = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b1, (i % 2 == 1) ? 10'h0AB : 10'h354);
        drain();
        check("mixed_no_lock", lock_idx, -1);
        for (int i = 0; i < 8; i++) drive(1'b1, 10'h154);
        drain();
        check("mixed_lock_index", lock_idx, 28);
        check("mixed_lock_ctrl", lock_ctrl, 2);

        // Gap timeout while locked: token as word 2047 prevents the slip
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 10'h354);
        enc_cnt = 0;
        for (int i = 0; i < 2046; i++) begin
            tmds_encode(8'(i * 7), q);
            drive(1'b1, q);
        end
        drive(1'b1, 10'h354);
        drain();
        check("gap_token_no_fall", fall_idx, -1);
        check("gap_token_locked", 32'(o_locked), 1);
        check("gap_token_offset", 32'(o_offset), 0);
        enc_cnt = 0;
        for (int i = 0; i < 2047; i++) begin
            tmds_encode(8'(i * 3), q);
            drive(1'b1, q);
        end
        drain();
        check("gap_fall_index", fall_idx, 4102);
        check("gap_fall_offset", fall_off, 1);

        // I_valid one cycle in three: lock counted in valid words
        do_reset();
        build_video(40);
        src_check = 1'b1;
        for (int j = 0; j < 40; j++) begin
            drive(1'b1, sym[j]);
            drive(1'b0, 10'($urandom));
            drive(1'b0, 10'($urandom));
        end
        drain();
        check("gapped_lock_index", lock_idx, 8);

        // Randomized bursts of tokens and noise with random valid gaps
        do_reset();
        src_check = 1'b0;
        left = 0; btok = 1'b0; bword = 10'd0;
        for (int c = 0; c < 6000; c++) begin
            bit v;
            if (left == 0) begin
                left  = int'($urandom_range(1, 12));
                btok  = ($urandom % 3) == 0;
                bword = tokens[$urandom % 4];
            end
            v = ($urandom % 4) != 0;
            drive(v, btok ? bword : 10'($urandom));
            if (v) left--;
        end
        drain();
        check("model_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
